// File: rtl/apb_bridge_ctrl_if.sv
// Bus bundle between the AHB slave stage, the APB-side bridge controller and the APB peripherals.
// The slave modport is the controller's view; master is the environment driving it.
interface apb_bridge_ctrl_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;

  // AHB side, from the slave interface stage
  logic          valid;
  logic          HWRITE;
  logic [AW-1:0] HADDR;
  logic [DW-1:0] HWDATA;
  logic [SW-1:0] TEMP_SEL;
  logic          HREADYout;
  logic [DW-1:0] HRDATA;

  // APB side
  logic [SW-1:0] PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          TIMEOUT;

  modport slave (
    input  valid, HWRITE, HADDR, HWDATA, TEMP_SEL, PREADY, PRDATA,
    output HREADYout, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA, TIMEOUT
  );

  modport master (
    output valid, HWRITE, HADDR, HWDATA, TEMP_SEL, PREADY, PRDATA,
    input  HREADYout, HRDATA, PSEL, PENABLE, PWRITE, PADDR, PWDATA, TIMEOUT
  );
endinterface

// File: rtl/apb_bridge_ctrl.sv
// APB-side controller of the AHB-to-APB bridge: one SETUP/ACCESS sequence per accepted AHB
// transfer, posted writes with a single pending slot, reads stall the master until PRDATA is valid.
module apb_bridge_ctrl #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic               HCLK,
  input  logic               HRESET,
  apb_bridge_ctrl_if.slave   bus
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 3;
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WWAIT  = 2'd1,
    S_SETUP  = 2'd2,
    S_ACCESS = 2'd3
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [SW-1:0]     r_psel,      w_psel_nxt;
  logic              r_penable,   w_penable_nxt;
  logic              r_pwrite,    w_pwrite_nxt;
  logic [AW-1:0]     r_paddr,     w_paddr_nxt;
  logic [DW-1:0]     r_pwdata,    w_pwdata_nxt;
  logic              r_timeout,   w_timeout_nxt;
  logic [AW-1:0]     r_addr_q,    w_addr_q_nxt;
  logic [SW-1:0]     r_sel_q,     w_sel_q_nxt;
  logic              r_pend_v,    w_pend_v_nxt;
  logic [AW-1:0]     r_pend_addr, w_pend_addr_nxt;
  logic [SW-1:0]     r_pend_sel,  w_pend_sel_nxt;
  logic              r_pend_wr,   w_pend_wr_nxt;
  logic [CNT_W-1:0]  r_wait_cnt,  w_wait_cnt_nxt;

  logic w_done;
  logic w_hready;
  logic w_accept;
  logic w_launch;

  // Unselected (unmapped) transfers and the last allowed wait cycle both end ACCESS.
  assign w_done = bus.PREADY | (r_psel == SW'(0)) | (r_wait_cnt == CNT_LAST);

  always_comb begin
    w_hready = 1'b0;
    case (r_state)
      S_IDLE, S_WWAIT: w_hready = 1'b1;
      S_ACCESS:        w_hready = w_done & ~r_pend_v;
      default:         w_hready = 1'b0;
    endcase
  end

  assign w_accept = bus.valid & w_hready;

  // State register and all registered outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_timeout   <= 1'b0;
      r_addr_q    <= '0;
      r_sel_q     <= '0;
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_sel  <= '0;
      r_pend_wr   <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_timeout   <= w_timeout_nxt;
      r_addr_q    <= w_addr_q_nxt;
      r_sel_q     <= w_sel_q_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pend_sel  <= w_pend_sel_nxt;
      r_pend_wr   <= w_pend_wr_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_timeout_nxt   = 1'b0;
    w_addr_q_nxt    = r_addr_q;
    w_sel_q_nxt     = r_sel_q;
    w_pend_v_nxt    = r_pend_v;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_sel_nxt  = r_pend_sel;
    w_pend_wr_nxt   = r_pend_wr;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_launch        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_launch = w_accept;
      end

      S_WWAIT: begin
        w_state_nxt  = S_SETUP;
        w_paddr_nxt  = r_addr_q;
        w_psel_nxt   = r_sel_q;
        w_pwrite_nxt = 1'b1;
        w_pwdata_nxt = bus.HWDATA;
        if (w_accept) begin
          w_pend_v_nxt    = 1'b1;
          w_pend_addr_nxt = bus.HADDR;
          w_pend_sel_nxt  = bus.TEMP_SEL;
          w_pend_wr_nxt   = bus.HWRITE;
        end
      end

      S_SETUP: begin
        w_state_nxt    = S_ACCESS;
        w_penable_nxt  = 1'b1;
        w_wait_cnt_nxt = '0;
      end

      S_ACCESS: begin
        if (!w_done) begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end else begin
          w_psel_nxt    = '0;
          w_penable_nxt = 1'b0;
          w_timeout_nxt = ~bus.PREADY & (r_psel != SW'(0));
          w_state_nxt   = S_IDLE;
          if (r_pend_v) begin
            w_pend_v_nxt = 1'b0;
            if (r_pend_wr) begin
              w_state_nxt  = S_WWAIT;
              w_addr_q_nxt = r_pend_addr;
              w_sel_q_nxt  = r_pend_sel;
            end else begin
              w_state_nxt  = S_SETUP;
              w_paddr_nxt  = r_pend_addr;
              w_psel_nxt   = r_pend_sel;
              w_pwrite_nxt = 1'b0;
            end
          end else begin
            w_launch = w_accept;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // New transfer taken straight from the AHB address phase.
    if (w_launch) begin
      if (bus.HWRITE) begin
        w_state_nxt  = S_WWAIT;
        w_addr_q_nxt = bus.HADDR;
        w_sel_q_nxt  = bus.TEMP_SEL;
      end else begin
        w_state_nxt  = S_SETUP;
        w_paddr_nxt  = bus.HADDR;
        w_psel_nxt   = bus.TEMP_SEL;
        w_pwrite_nxt = 1'b0;
      end
    end
  end

  assign bus.HREADYout = w_hready;
  assign bus.HRDATA    = bus.PRDATA;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.TIMEOUT   = r_timeout;

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Directed bench for apb_bridge_ctrl: reads, posted writes, back-to-back pending, wait states,
// forced completion, reset mid-transfer and unmapped access.
module tb_apb_bridge_ctrl;

  logic HCLK = 1'b0;
  logic HRESET;

  always #5 HCLK = ~HCLK;

  apb_bridge_ctrl_if bus();

  apb_bridge_ctrl #(.WAIT_MAX(16)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid    = 1'b0;
    bus.HWRITE   = 1'b0;
    bus.HADDR    = 32'h0;
    bus.HWDATA   = 32'h0;
    bus.TEMP_SEL = 3'b000;
    bus.PREADY   = 1'b1;
    bus.PRDATA   = 32'h0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    idle_inputs();
    tick();
    tick();
    HRESET = 1'b0;
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.TIMEOUT, bus.HREADYout} !== 7'b000_0_0_0_1) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.TIMEOUT, bus.HREADYout}, 7'b0000001);
    end
    n_cmp++;
    if ({bus.PADDR, bus.PWDATA} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", {bus.PADDR, bus.PWDATA});
    end
  endtask

  task automatic test_read();
    tick();
    bus.valid = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = 32'h4000_1004;
    bus.TEMP_SEL = 3'b010; bus.PREADY = 1'b1; bus.PRDATA = 32'h1234_5678;
    @(negedge HCLK);
    n_cmp++;
    if (bus.HREADYout !== 1'b1) begin
      n_err++; $display("FAIL read_accept_hready: got %b expected 1", bus.HREADYout);
    end
    tick();  // SETUP
    bus.valid = 1'b0;
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYout, bus.PWRITE, bus.PADDR} !== {3'b010, 3'b000, 32'h4000_1004}) begin
      n_err++; $display("FAIL read_setup: got %b %h expected 010000 40001004",
                        {bus.PSEL, bus.PENABLE, bus.HREADYout, bus.PWRITE}, bus.PADDR);
    end
    tick();  // ACCESS
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYout, bus.HRDATA} !== {3'b010, 2'b11, 32'h1234_5678}) begin
      n_err++; $display("FAIL read_access: got %b %h expected 01011 12345678",
                        {bus.PSEL, bus.PENABLE, bus.HREADYout}, bus.HRDATA);
    end
    tick();  // IDLE
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYout, bus.PADDR} !== {3'b000, 2'b01, 32'h4000_1004}) begin
      n_err++; $display("FAIL read_end: got %b %h expected 00001 40001004",
                        {bus.PSEL, bus.PENABLE, bus.HREADYout}, bus.PADDR);
    end
  endtask

  task automatic test_write();
    bus.valid = 1'b1; bus.HWRITE = 1'b1; bus.HADDR = 32'h4000_0008;
    bus.TEMP_SEL = 3'b001; bus.PREADY = 1'b1;
    tick();  // WWAIT
    bus.valid = 1'b0; bus.HWDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    n_cmp++;
    if ({bus.HREADYout, bus.PSEL, bus.PENABLE} !== 5'b1_000_0) begin
      n_err++; $display("FAIL write_wwait: got %b expected 10000", {bus.HREADYout, bus.PSEL, bus.PENABLE});
    end
    tick();  // SETUP
    bus.HWDATA = 32'h0;
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYout, bus.PWRITE, bus.PADDR, bus.PWDATA} !==
        {3'b001, 3'b001, 32'h4000_0008, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL write_setup: got %b %h %h expected 001001 40000008 deadbeef",
                        {bus.PSEL, bus.PENABLE, bus.HREADYout, bus.PWRITE}, bus.PADDR, bus.PWDATA);
    end
    tick();  // ACCESS
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PENABLE, bus.HREADYout} !== 2'b11) begin
      n_err++; $display("FAIL write_access: got %b expected 11", {bus.PENABLE, bus.HREADYout});
    end
    tick();  // IDLE
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.PWDATA} !== {4'b0000, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL write_end: got %b %h expected 0000 deadbeef", {bus.PSEL, bus.PENABLE}, bus.PWDATA);
    end
  endtask

  task automatic test_back_to_back();
    bus.valid = 1'b1; bus.HWRITE = 1'b1; bus.HADDR = 32'h4000_2000;
    bus.TEMP_SEL = 3'b100; bus.PREADY = 1'b1;
    tick();  // WWAIT: read accepted here
    bus.valid = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = 32'h4000_0010;
    bus.TEMP_SEL = 3'b001; bus.HWDATA = 32'hCAFE_F00D;
    @(negedge HCLK);
    n_cmp++;
    if (bus.HREADYout !== 1'b1) begin
      n_err++; $display("FAIL b2b_wwait_hready: got %b expected 1", bus.HREADYout);
    end
    tick();  // write SETUP
    bus.valid = 1'b0;
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PWRITE, bus.HREADYout, bus.PWDATA} !== {3'b100, 2'b10, 32'hCAFE_F00D}) begin
      n_err++; $display("FAIL b2b_wr_setup: got %b %h expected 10010 cafef00d",
                        {bus.PSEL, bus.PWRITE, bus.HREADYout}, bus.PWDATA);
    end
    tick();  // write ACCESS with pending read
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PENABLE, bus.HREADYout} !== 2'b10) begin
      n_err++; $display("FAIL b2b_wr_done_stall: got %b expected 10", {bus.PENABLE, bus.HREADYout});
    end
    tick();  // read SETUP directly
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.HREADYout, bus.PADDR} !== {3'b001, 3'b000, 32'h4000_0010}) begin
      n_err++; $display("FAIL b2b_rd_setup: got %b %h expected 001000 40000010",
                        {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.HREADYout}, bus.PADDR);
    end
    tick();  // read ACCESS
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYout} !== 5'b001_1_1) begin
      n_err++; $display("FAIL b2b_rd_access: got %b expected 00111", {bus.PSEL, bus.PENABLE, bus.HREADYout});
    end
    tick();
  endtask

  task automatic test_wait_states();
    int acc_cnt = 0;
    int to_cnt  = 0;
    int hr_cnt  = 0;
    bus.valid = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = 32'h4000_3000;
    bus.TEMP_SEL = 3'b010; bus.PREADY = 1'b0;
    tick();  // SETUP
    bus.valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.PREADY = (i >= 3);
      @(negedge HCLK);
      if (bus.PENABLE) begin
        acc_cnt++;
        if (bus.HREADYout) hr_cnt++;
      end
      if (bus.TIMEOUT) to_cnt++;
    end
    n_cmp++;
    if (acc_cnt !== 4) begin
      n_err++; $display("FAIL wait_access_cycles: got %0d expected 4", acc_cnt);
    end
    n_cmp++;
    if ({to_cnt, hr_cnt} !== {32'd0, 32'd1}) begin
      n_err++; $display("FAIL wait_timeout_hready: got timeout=%0d hready=%0d expected 0 1", to_cnt, hr_cnt);
    end
    bus.PREADY = 1'b1;
  endtask

  task automatic test_timeout();
    int acc_cnt = 0;
    int to_cnt  = 0;
    int to_idx  = -1;
    logic hr_last = 1'b0;
    bus.valid = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = 32'h4000_3004;
    bus.TEMP_SEL = 3'b100; bus.PREADY = 1'b0;
    tick();  // SETUP
    bus.valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      @(negedge HCLK);
      if (bus.PENABLE) acc_cnt++;
      if (i == 15) hr_last = bus.HREADYout;
      if (bus.TIMEOUT) begin
        to_cnt++;
        if (to_idx < 0) to_idx = i;
      end
    end
    n_cmp++;
    if (acc_cnt !== 16) begin
      n_err++; $display("FAIL timeout_access_cycles: got %0d expected 16", acc_cnt);
    end
    n_cmp++;
    if ({to_cnt, to_idx} !== {32'd1, 32'd16}) begin
      n_err++; $display("FAIL timeout_pulse: got count=%0d at=%0d expected 1 at 16", to_cnt, to_idx);
    end
    n_cmp++;
    if ({hr_last, bus.HREADYout, bus.PSEL, bus.PENABLE} !== 6'b11_000_0) begin
      n_err++; $display("FAIL timeout_idle: got %b expected 110000", {hr_last, bus.HREADYout, bus.PSEL, bus.PENABLE});
    end
    bus.PREADY = 1'b1;
  endtask

  task automatic test_reset_mid_and_unmapped();
    int stray = 0;
    bus.valid = 1'b1; bus.HWRITE = 1'b1; bus.HADDR = 32'h4000_4000;
    bus.TEMP_SEL = 3'b001; bus.PREADY = 1'b0;
    tick();  // WWAIT: pending write accepted
    bus.HADDR = 32'h4000_5000; bus.TEMP_SEL = 3'b010; bus.HWDATA = 32'h1111_2222;
    tick();  // SETUP
    bus.valid = 1'b0;
    tick();  // ACCESS, stalled
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PENABLE, bus.HREADYout, bus.PSEL} !== 5'b10_001) begin
      n_err++; $display("FAIL rst_pre_access: got %b expected 10001", {bus.PENABLE, bus.HREADYout, bus.PSEL});
    end
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    bus.PREADY = 1'b1;
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.TIMEOUT, bus.HREADYout, bus.PADDR} !== {6'b000_0_0_1, 32'h0}) begin
      n_err++; $display("FAIL rst_mid: got %b %h expected 000001 00000000",
                        {bus.PSEL, bus.PENABLE, bus.TIMEOUT, bus.HREADYout}, bus.PADDR);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge HCLK);
      if (bus.PSEL != 3'b000 || bus.PENABLE) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_err++; $display("FAIL rst_pend_discard: got %0d active cycles expected 0", stray);
    end
    // Unmapped read: PSEL stays 0, ACCESS lasts one cycle even with PREADY low
    bus.valid = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = 32'h4000_9000;
    bus.TEMP_SEL = 3'b000; bus.PREADY = 1'b0;
    tick();  // SETUP
    bus.valid = 1'b0;
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYout, bus.PADDR} !== {5'b000_0_0, 32'h4000_9000}) begin
      n_err++; $display("FAIL unmapped_setup: got %b %h expected 00000 40009000",
                        {bus.PSEL, bus.PENABLE, bus.HREADYout}, bus.PADDR);
    end
    tick();  // ACCESS
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PSEL, bus.PENABLE, bus.HREADYout} !== 5'b000_1_1) begin
      n_err++; $display("FAIL unmapped_access: got %b expected 00011", {bus.PSEL, bus.PENABLE, bus.HREADYout});
    end
    tick();  // IDLE
    @(negedge HCLK);
    n_cmp++;
    if ({bus.PENABLE, bus.TIMEOUT, bus.HREADYout} !== 3'b001) begin
      n_err++; $display("FAIL unmapped_end: got %b expected 001", {bus.PENABLE, bus.TIMEOUT, bus.HREADYout});
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_reset_mid_and_unmapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
